// File: rtl/sensor_pattern_gen.sv
// Four-phase two-line pass pattern source for the two-sensor direction detector.
// Optional build macro PASS_CNT_EN adds an 8-bit count of completed passes.
module sensor_pattern_gen #(
    parameter int HOLD_CYCLES = 1,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] dir,
    input  logic       abort,
    output logic       sensor1_data,
    output logic       sensor2_data,
    output logic       busy,
    output logic       done,
    output logic       err,
`ifdef PASS_CNT_EN
    output logic [7:0] pass_count,
`endif
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH1  = 3'd1,
        PH2  = 3'd2,
        PH3  = 3'd3,
        PH4  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             dir_q, dir_nxt;   // 1 = sensor2 leads
    logic             s1_nxt, s2_nxt, busy_nxt, done_nxt, err_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dir_nxt   = dir_q;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                if (dir == 2'b01 || dir == 2'b10) begin
                    state_nxt = PH1;
                    cnt_nxt   = HOLD_LOAD;
                    dir_nxt   = dir[1];
                end else begin
                    err_nxt = 1'b1;
                end
            end
        end else if (abort) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
        end else begin
            case (state)
                PH1: begin state_nxt = PH2; cnt_nxt = HOLD_LOAD; end
                PH2: begin state_nxt = PH3; cnt_nxt = HOLD_LOAD; end
                PH3: begin state_nxt = PH4; cnt_nxt = GAP_LOAD;  end
                PH4: begin state_nxt = IDLE; cnt_nxt = '0; done_nxt = 1'b1; end
                default: begin state_nxt = IDLE; cnt_nxt = '0; end
            endcase
        end
        // Outputs are registered, so the pattern is decoded from the next state.
        busy_nxt = (state_nxt != IDLE);
        s1_nxt   = (state_nxt == PH1 && !dir_nxt) || (state_nxt == PH2) ||
                   (state_nxt == PH3 && dir_nxt);
        s2_nxt   = (state_nxt == PH1 && dir_nxt) || (state_nxt == PH2) ||
                   (state_nxt == PH3 && !dir_nxt);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            dir_q        <= 1'b0;
            sensor1_data <= 1'b0;
            sensor2_data <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            dir_q        <= dir_nxt;
            sensor1_data <= s1_nxt;
            sensor2_data <= s2_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            err          <= err_nxt;
        end
    end

`ifdef PASS_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            pass_count <= 8'd0;
        end else if (done_nxt) begin
            pass_count <= pass_count + 8'd1;
        end
    end
`endif

    assign state_dbg = state;

endmodule

// File: tb/tb_sensor_pattern_gen.sv
// Bench for sensor_pattern_gen: two instances (HOLD/GAP 1/1 and 3/2) on shared inputs,
// checked against hand vectors and a pass-timeline reference model.
module tb_sensor_pattern_gen;

    localparam int HA = 1, GA = 1, HB = 3, GB = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [1:0] dir = 2'b00;
    logic       abort = 1'b0;
    logic       s1_a, s2_a, busy_a, done_a, err_a;
    logic       s1_b, s2_b, busy_b, done_b, err_b;
    logic [2:0] st_a, st_b;
`ifdef PASS_CNT_EN
    logic [7:0] pc_a, pc_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sensor_pattern_gen #(.HOLD_CYCLES(HA), .GAP_CYCLES(GA), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .start(start), .dir(dir), .abort(abort),
        .sensor1_data(s1_a), .sensor2_data(s2_a), .busy(busy_a), .done(done_a), .err(err_a),
`ifdef PASS_CNT_EN
        .pass_count(pc_a),
`endif
        .state_dbg(st_a)
    );

    sensor_pattern_gen #(.HOLD_CYCLES(HB), .GAP_CYCLES(GB), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .start(start), .dir(dir), .abort(abort),
        .sensor1_data(s1_b), .sensor2_data(s2_b), .busy(busy_b), .done(done_b), .err(err_b),
`ifdef PASS_CNT_EN
        .pass_count(pc_b),
`endif
        .state_dbg(st_b)
    );

    // Reference model: a pass is a timeline t = clocks since accept.
    bit   m_act[2];
    int   m_t[2];
    bit   m_d2[2];
    bit   m_done[2];
    bit   m_err[2];
    int   m_pc[2];

    task automatic model_edge(input int i, input int h, input int g);
        m_done[i] = 1'b0;
        m_err[i]  = 1'b0;
        if (!reset) begin
            m_act[i] = 1'b0;
            m_t[i]   = 0;
            m_pc[i]  = 0;
        end else if (m_act[i]) begin
            if (abort) begin
                m_act[i] = 1'b0;
            end else begin
                m_t[i]++;
                if (m_t[i] == 3 * h + g) begin
                    m_act[i]  = 1'b0;
                    m_done[i] = 1'b1;
                    m_pc[i]   = (m_pc[i] + 1) % 256;
                end
            end
        end else if (start) begin
            if (dir == 2'b01 || dir == 2'b10) begin
                m_act[i] = 1'b1;
                m_t[i]   = 0;
                m_d2[i]  = (dir == 2'b10);
            end else begin
                m_err[i] = 1'b1;
            end
        end
    endtask

    function automatic logic [4:0] model_out(input int i, input int h);
        logic [1:0] s;
        s = 2'b00;
        if (m_act[i] && m_t[i] < 3 * h) begin
            case (m_t[i] / h)
                0:       s = m_d2[i] ? 2'b01 : 2'b10;
                1:       s = 2'b11;
                default: s = m_d2[i] ? 2'b10 : 2'b01;
            endcase
        end
        return {s, m_act[i], m_done[i], m_err[i]};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] out_a();
        return {s1_a, s2_a, busy_a, done_a, err_a};
    endfunction

    function automatic logic [4:0] out_b();
        return {s1_b, s2_b, busy_b, done_b, err_b};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge(0, HA, GA);
        model_edge(1, HB, GB);
        #1;
        chk("model_a", int'(out_a()), int'(model_out(0, HA)));
        chk("model_b", int'(out_b()), int'(model_out(1, HB)));
`ifdef PASS_CNT_EN
        chk("model_pc_a", int'(pc_a), m_pc[0]);
        chk("model_pc_b", int'(pc_b), m_pc[1]);
`endif
    endtask

    task automatic drive(input logic r, input logic s, input logic [1:0] d, input logic a);
        reset = r;
        start = s;
        dir   = d;
        abort = a;
    endtask

    typedef struct {
        logic       r;
        logic       s;
        logic [1:0] d;
        logic       a;
        logic [4:0] exp;   // {sensor1, sensor2, busy, done, err} of the 1/1 instance
    } vec_t;

    vec_t vecs[15];
    int   cnt;

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 2'b01, 1'b0, 5'b00_000};
        vecs[1]  = '{1'b0, 1'b1, 2'b01, 1'b1, 5'b00_000};
        vecs[2]  = '{1'b1, 1'b1, 2'b01, 1'b1, 5'b10_100};
        vecs[3]  = '{1'b1, 1'b0, 2'b10, 1'b0, 5'b11_100};
        vecs[4]  = '{1'b1, 1'b1, 2'b10, 1'b0, 5'b01_100};
        vecs[5]  = '{1'b1, 1'b0, 2'b00, 1'b0, 5'b00_100};
        vecs[6]  = '{1'b1, 1'b0, 2'b00, 1'b0, 5'b00_010};
        vecs[7]  = '{1'b1, 1'b1, 2'b10, 1'b0, 5'b01_100};
        vecs[8]  = '{1'b1, 1'b0, 2'b01, 1'b0, 5'b11_100};
        vecs[9]  = '{1'b1, 1'b0, 2'b01, 1'b0, 5'b10_100};
        vecs[10] = '{1'b1, 1'b0, 2'b00, 1'b0, 5'b00_100};
        vecs[11] = '{1'b1, 1'b0, 2'b00, 1'b0, 5'b00_010};
        vecs[12] = '{1'b1, 1'b1, 2'b00, 1'b0, 5'b00_001};
        vecs[13] = '{1'b1, 1'b1, 2'b11, 1'b1, 5'b00_001};
        vecs[14] = '{1'b1, 1'b0, 2'b01, 1'b1, 5'b00_000};

        for (int k = 0; k < 15; k++) begin
            drive(vecs[k].r, vecs[k].s, vecs[k].d, vecs[k].a);
            step();
            chk($sformatf("vec%0d", k), int'(out_a()), int'(vecs[k].exp));
        end

        // abort during PH2
        drive(1'b0, 1'b0, 2'b00, 1'b0); step();
        drive(1'b1, 1'b1, 2'b01, 1'b0); step();
        drive(1'b1, 1'b0, 2'b01, 1'b0); step();
        chk("ph2_a", int'(out_a()), 5'b11_100);
        drive(1'b1, 1'b0, 2'b01, 1'b1); step();
        chk("abort_a", int'(out_a()), 5'b00_000);
        drive(1'b1, 1'b0, 2'b01, 1'b0); step();
        chk("abort_nodone_a", int'(out_a()), 5'b00_000);

        // reset during PH3, then a fresh start
        drive(1'b1, 1'b1, 2'b01, 1'b0); step();
        drive(1'b1, 1'b0, 2'b01, 1'b0); step(); step();
        chk("ph3_a", int'(out_a()), 5'b01_100);
        drive(1'b0, 1'b0, 2'b01, 1'b0); step();
        chk("rst_ph3_a", int'(out_a()), 5'b00_000);
        drive(1'b1, 1'b1, 2'b10, 1'b0); step();
        chk("restart_a", int'(out_a()), 5'b01_100);
        drive(1'b1, 1'b0, 2'b10, 1'b0);

        // HOLD=3/GAP=2 pass length, accept edge to done edge
        drive(1'b0, 1'b0, 2'b00, 1'b0); step();
        drive(1'b1, 1'b1, 2'b01, 1'b0); step();
        drive(1'b1, 1'b0, 2'b01, 1'b0);
        cnt = 0;
        while (!done_b && cnt < 40) begin
            step();
            cnt++;
        end
        chk("b_pass_len", cnt, 3 * HB + GB);

        // start while the 3/2 instance is in PH2: no second pass, no err
        drive(1'b0, 1'b0, 2'b00, 1'b0); step();
        drive(1'b1, 1'b1, 2'b10, 1'b0); step();
        drive(1'b1, 1'b0, 2'b10, 1'b0); step(); step(); step();
        chk("b_in_ph2", int'(out_b()), 5'b11_100);
        drive(1'b1, 1'b1, 2'b01, 1'b0); step();
        chk("b_ignored_start", int'(out_b()), 5'b11_100);
        drive(1'b1, 1'b0, 2'b01, 1'b0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (done_b) cnt++;
        end
        chk("b_one_done", cnt, 1);

`ifdef PASS_CNT_EN
        drive(1'b0, 1'b0, 2'b00, 1'b0); step();
        for (int p = 0; p < 3; p++) begin
            drive(1'b1, 1'b1, 2'b01, 1'b0); step();
            drive(1'b1, 1'b0, 2'b01, 1'b0);
            repeat (4) step();
        end
        drive(1'b1, 1'b1, 2'b10, 1'b0); step();
        drive(1'b1, 1'b0, 2'b10, 1'b1); step();
        drive(1'b1, 1'b0, 2'b10, 1'b0); step();
        chk("pc_three", int'(pc_a), 3);
        for (int p = 0; p < 253; p++) begin
            drive(1'b1, 1'b1, 2'b10, 1'b0); step();
            drive(1'b1, 1'b0, 2'b10, 1'b0);
            repeat (4) step();
        end
        chk("pc_wrap", int'(pc_a), 0);
`endif

        // randomized traffic against the reference model
        drive(1'b0, 1'b0, 2'b00, 1'b0); step();
        for (int k = 0; k < 1500; k++) begin
            drive(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 3) == 0),
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 19) == 0));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_pattern_gen.md
Name: sensor_pattern_gen

Overview:
- Stimulus source for the two-sensor direction detector: the transmit side of the same two-line protocol.
- On command, drives `sensor1_data`/`sensor2_data` through the four-phase pass sequence that an object moving in the commanded direction produces.
- Used as a bench/emulation source and as a built-in self-test driver feeding the detector.
- Direction encoding matches the detector output: 2'b01 = sensor1 first, 2'b10 = sensor2 first.

Parameters:
- HOLD_CYCLES, 1, clocks each of phases 1-3 is held; legal range 1..255.
- GAP_CYCLES, 1, clocks the idle phase (both low) is held after phase 3; legal range 1..255.
- CNT_W, 8, width of the hold/gap down-counter; must satisfy 2^CNT_W > max(HOLD_CYCLES, GAP_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request one pass; sampled only in IDLE.
- dir  input  2  commanded direction, sampled with start: 01 = sensor1 first, 10 = sensor2 first.
- abort  input  1  terminates the current pass immediately.
- sensor1_data  output  1  emulated sensor 1 line, registered.
- sensor2_data  output  1  emulated sensor 2 line, registered.
- busy  output  1  high while a pass is in progress.
- done  output  1  one-cycle pulse at normal completion of a pass.
- err  output  1  one-cycle pulse when start is seen with an illegal dir.

Behaviour:
- All outputs are registered. The state is updated only on rising `clk`.
- Reset: on any edge with reset=0, the block enters IDLE and sensor1_data = sensor2_data = busy = done = err = 0, counter = 0. Reset overrides start and abort. Reset mid-pass discards the pass with no done.
- States: IDLE, PH1, PH2, PH3, PH4. The direction is latched into a 1-bit register at accept.
- Sensor pairs {sensor1,sensor2} per state:
  - dir=01: PH1=10, PH2=11, PH3=01, PH4=00.
  - dir=10: PH1=01, PH2=11, PH3=10, PH4=00.
  - IDLE=00.
- Accept: in IDLE, on an edge with start=1 and dir in {01,10}:
  - next state is PH1;
  - PH1 pattern and busy=1 are visible after that same edge, giving a latency of one clock from the sampled start to the first pattern.
- Illegal dir (00 or 11) with start=1 in IDLE: remain IDLE, err=1 for exactly one cycle, sensors stay 00.
- Phase timing:
  - PH1, PH2, PH3 each last exactly HOLD_CYCLES clocks; PH4 lasts GAP_CYCLES clocks.
  - The counter loads (N-1) on phase entry, decrements each clock, and the state advances when the counter = 0.
- Completion: on the edge leaving PH4, the state returns to IDLE, busy=0 and done=1 for one cycle.
- A new start sampled in that same IDLE cycle is accepted normally. Back-to-back passes therefore have one IDLE cycle (00) between them.
- start while busy: ignored, with no queueing and no err.
- dir changes while busy: ignored; the latched direction is used.
- abort=1 while busy: on the next edge the state goes to IDLE, sensors=00, busy=0, done=0.
- abort=1 in IDLE: no effect. abort has priority over a phase advance on the same edge.
- start and abort together in IDLE: start wins and abort is ignored.
- Total pass length, accept edge to done edge, is 3*HOLD_CYCLES + GAP_CYCLES clocks.
- The pattern order guarantees that only one sensor line changes per phase transition. An exception exists at the PH4->IDLE->PH1 boundary: both lines are already 0 there, so there is no double change.

Optional Feature:
- Macro: `PASS_CNT_EN`.
- Defined:
  - adds output `pass_count`, 8 bits, reset to 0;
  - increments by 1 in the same edge that asserts done, separately for either direction, wrapping 255->0;
  - abort, illegal-dir and ignored starts do not count.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Reset with HOLD=GAP=1, then reset=0 for 2 clocks with start=1 -> all outputs 0 and no pass starts. After reset=1, start=1 dir=01 for one clock -> sensors 10,11,01,00 on successive cycles, busy=1 for 4 cycles, done=1 in the 5th cycle.
- HOLD=1: start with dir=10 -> sensors 01,11,10,00, then done. Feeding the detector, direction reads 10 after the pass; for dir=01 it reads 01.
- HOLD=3, GAP=2: each of 10/11/01 is held 3 clocks and 00 is held 2 clocks; done arrives 11 clocks after accept.
- start with dir=00, then dir=11 -> err pulses one cycle each, sensors stay 00, busy=0. Then start dir=01 while busy mid-PH2 -> ignored and only one done.
- abort asserted during PH2 -> next cycle sensors=00, busy=0, no done. Reset asserted during PH3 -> same result, next start accepted normally.
- With `PASS_CNT_EN`: 3 completed passes plus 1 aborted pass -> pass_count=3. Running 256 completed passes -> wraps to 0.
